// File: rtl/alu_pkg.sv
// Shared encodings, flag indices, FSM states and op decode for the sequential ALU.
package alu_pkg;

  // Register-form {opcode, opext} encodings.
  localparam logic [7:0] ENC_AND    = 8'b0000_0001;
  localparam logic [7:0] ENC_OR     = 8'b0000_0010;
  localparam logic [7:0] ENC_XOR    = 8'b0000_0011;
  localparam logic [7:0] ENC_ADD    = 8'b0000_0101;
  localparam logic [7:0] ENC_ADDU   = 8'b0000_0110;
  localparam logic [7:0] ENC_ADDC   = 8'b0000_0111;
  localparam logic [7:0] ENC_SUB    = 8'b0000_1001;
  localparam logic [7:0] ENC_CMP    = 8'b0000_1011;
  localparam logic [7:0] ENC_MOV    = 8'b0000_1101;
  localparam logic [7:0] ENC_RSH    = 8'b0000_1110;
  localparam logic [7:0] ENC_LSH    = 8'b1000_0100;
  localparam logic [7:0] ENC_CMPU   = 8'b1010_0010;
  localparam logic [7:0] ENC_NOT    = 8'b1010_0011;
  localparam logic [7:0] ENC_ARSH   = 8'b1010_0100;
  localparam logic [7:0] ENC_ADDCU  = 8'b1010_0101;
  localparam logic [7:0] ENC_ADDCUI = 8'b1010_0110;
  localparam logic [7:0] ENC_MUL    = 8'b1010_1000;

  // CLFZN bit positions.
  localparam int unsigned FLG_C = 4;
  localparam int unsigned FLG_L = 3;
  localparam int unsigned FLG_F = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_N = 0;

  // Top-level FSM states.
  typedef logic [0:0] state_t;
  localparam state_t StIdle = 1'b0;
  localparam state_t StExec = 1'b1;

  typedef enum logic [3:0] {
    OpNone, OpAdd, OpAddu, OpAddc, OpAddcu, OpSub, OpCmp, OpAnd,
    OpOr, OpXor, OpNot, OpMov, OpLsh, OpRsh, OpArsh, OpMul
  } op_e;

  typedef enum logic [1:0] {IterLsh, IterRsh, IterArsh, IterMul} iter_mode_e;

  // Exact encodings are listed before the immediate wildcards; LSH overlaps LSHI harmlessly.
  function automatic op_e decode_op(input logic [7:0] enc);
    op_e op;
    op = OpNone;
    casez (enc)
      ENC_ADD,   8'b0101_????: op = OpAdd;
      ENC_ADDU,  8'b0110_????: op = OpAddu;
      ENC_ADDC,  8'b0111_????: op = OpAddc;
      ENC_ADDCU, ENC_ADDCUI:   op = OpAddcu;
      ENC_SUB,   8'b1001_????: op = OpSub;
      ENC_CMP,   ENC_CMPU,
      8'b1011_????:            op = OpCmp;
      ENC_AND,   8'b0001_????: op = OpAnd;
      ENC_OR,    8'b0010_????: op = OpOr;
      ENC_XOR,   8'b0011_????: op = OpXor;
      ENC_NOT:                 op = OpNot;
      ENC_MOV,   8'b1101_????: op = OpMov;
      ENC_LSH,   8'b1000_????: op = OpLsh;
      ENC_RSH,   8'b1110_????: op = OpRsh;
      ENC_ARSH:                op = OpArsh;
      ENC_MUL:                 op = OpMul;
      default:                 op = OpNone;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath shared by multi-bit shifts and shift-add multiply: one bit per step.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     step_i,
  input  iter_mode_e               mode_i,
  input  logic [WIDTH-1:0]         a_i,
  input  logic [WIDTH-1:0]         b_i,
  input  logic [$clog2(WIDTH)-1:0] n_i,
  output logic                     last_o,
  output logic [WIDTH-1:0]         res_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  iter_mode_e       mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] mp_q, mp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] step_res;

  // Value the accumulator takes after one more step.
  always_comb begin
    step_res = acc_q;
    case (mode_q)
      IterLsh:  step_res = {acc_q[WIDTH-2:0], 1'b0};
      IterRsh:  step_res = {1'b0, acc_q[WIDTH-1:1]};
      IterArsh: step_res = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      IterMul:  step_res = acc_q + (mp_q[0] ? mc_q : '0);
      default:  step_res = acc_q;
    endcase
  end

  // Load operands or advance one iteration.
  always_comb begin
    mode_d = mode_q;
    acc_d  = acc_q;
    mc_d   = mc_q;
    mp_d   = mp_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      mode_d = mode_i;
      acc_d  = (mode_i == IterMul) ? '0 : a_i;
      mc_d   = a_i;
      mp_d   = b_i;
      cnt_d  = (mode_i == IterMul) ? CW'(WIDTH) : CW'(n_i);
    end else if (step_i) begin
      acc_d = step_res;
      mc_d  = {mc_q[WIDTH-2:0], 1'b0};
      mp_d  = {1'b0, mp_q[WIDTH-1:1]};
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= IterLsh;
      acc_q  <= '0;
      mc_q   <= '0;
      mp_q   <= '0;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      acc_q  <= acc_d;
      mc_q   <= mc_d;
      mp_q   <= mp_d;
      cnt_q  <= cnt_d;
    end
  end

  // The step taken while the counter reads 1 is the final one.
  assign last_o = (cnt_q == CW'(1));
  assign res_o  = step_res;

endmodule

// File: rtl/alu_seq.sv
// Registered CR16-style ALU: latches a request, executes single-cycle ops directly and hands
// shifts (n>0) and MUL to the iterative unit, holding result and CLFZN flags internally.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [3:0]       opext,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic [4:0]       CLFZN
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [4:0]       flags_q, flags_d;

  logic             accept, exec, is_shift, is_multi, iter_load, iter_step, iter_last, finish;
  logic [SHW-1:0]   n_w;
  logic             cin_w;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] diff_w, res_s, iter_res;
  logic [4:0]       flg_s;
  iter_mode_e       iter_mode;

  // Request acceptance and classification of the latched op.
  always_comb begin
    accept    = start & ~busy_q;
    exec      = pend_q & (state_q == StIdle);
    n_w       = b_q[SHW-1:0];
    is_shift  = op_q inside {OpLsh, OpRsh, OpArsh};
    is_multi  = (op_q == OpMul) | (is_shift & (n_w != '0));
    iter_load = exec & is_multi;
    iter_step = (state_q == StExec);
    finish    = iter_step & iter_last;
    case (op_q)
      OpLsh:   iter_mode = IterLsh;
      OpRsh:   iter_mode = IterRsh;
      OpArsh:  iter_mode = IterArsh;
      default: iter_mode = IterMul;
    endcase
  end

  // Single-cycle arithmetic and flag update.
  always_comb begin
    cin_w  = (op_q inside {OpAddc, OpAddcu}) ? flags_q[FLG_C] : 1'b0;
    sum_w  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_w};
    diff_w = a_q - b_q;
    res_s  = s_q;
    flg_s  = flags_q;
    case (op_q)
      OpAdd, OpAddc: begin
        res_s        = sum_w[MSB:0];
        flg_s[FLG_C] = sum_w[WIDTH];
        flg_s[FLG_F] = (a_q[MSB] == b_q[MSB]) && (sum_w[MSB] != a_q[MSB]);
      end
      OpAddu, OpAddcu: begin
        res_s        = sum_w[MSB:0];
        flg_s[FLG_C] = sum_w[WIDTH];
        flg_s[FLG_F] = sum_w[WIDTH];
      end
      OpSub: begin
        res_s        = diff_w;
        flg_s[FLG_C] = (a_q < b_q);
        flg_s[FLG_F] = (a_q[MSB] != b_q[MSB]) && (diff_w[MSB] == b_q[MSB]);
      end
      OpCmp: begin
        flg_s[FLG_C] = 1'b0;
        flg_s[FLG_F] = 1'b0;
        flg_s[FLG_L] = (a_q > b_q);
        flg_s[FLG_Z] = (a_q == b_q);
        flg_s[FLG_N] = ($signed(a_q) > $signed(b_q));
      end
      OpAnd:                res_s = a_q & b_q;
      OpOr:                 res_s = a_q | b_q;
      OpXor:                res_s = a_q ^ b_q;
      OpNot:                res_s = ~a_q;
      OpMov:                res_s = a_q;
      // Only reached here with n=0; longer shifts go through the iterative unit.
      OpLsh, OpRsh, OpArsh: res_s = a_q;
      // MUL is iterative; undefined encodings leave S and flags as they are.
      default:              res_s = s_q;
    endcase
  end

  // Next-state for the request latch, FSM and result registers.
  always_comb begin
    pend_d  = pend_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    s_d     = s_q;
    flags_d = flags_q;
    if (exec) pend_d = 1'b0;
    if (accept) begin
      pend_d = 1'b1;
      op_d   = decode_op({opcode, opext});
      a_d    = A;
      b_d    = B;
    end
    if (exec && !is_multi) begin
      s_d     = res_s;
      flags_d = flg_s;
      done_d  = 1'b1;
    end
    if (iter_load) begin
      state_d = StExec;
      busy_d  = 1'b1;
    end
    if (finish) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      s_d     = iter_res;
      done_d  = 1'b1;
    end
  end

  // State registers; reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      op_q    <= OpNone;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      flags_q <= flags_d;
    end
  end

  alu_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (iter_load),
    .step_i (iter_step),
    .mode_i (iter_mode),
    .a_i    (a_q),
    .b_i    (b_q),
    .n_i    (n_w),
    .last_o (iter_last),
    .res_o  (iter_res)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign CLFZN = flags_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the combinational CR16-style ALU. It executes the same `{opcode, opext}` instruction set at a configurable WIDTH and holds the CLFZN flag register internally, so ADDC/ADDCU take carry from the stored C flag. It also adds multi-bit shifts and a shift-add multiply, both run iteratively under a start/busy/done handshake. It sits between register-file read and write-back in the datapath; the controller stalls on `busy`.

## Interface
- `WIDTH`, 16: datapath width; power of two, ≥ 4.
- `SHW`: localparam, `$clog2(WIDTH)`; width of the shift amount.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only when `busy`=0.
- `opcode`  in  4: major opcode.
- `opext`  in  4: extension; ignored for immediate forms.
- `A`  in  WIDTH: destination/first operand.
- `B`  in  WIDTH: source operand or sign-extended immediate.
- `busy`  out  1: iterative operation in progress.
- `done`  out  1: one-cycle pulse; `S` and `CLFZN` valid from this cycle.
- `S`  out  WIDTH: registered result; holds until the next completion.
- `CLFZN`  out  5: registered flags; bit4 C, bit3 L, bit2 F, bit1 Z, bit0 N.

## Operation
- Operands and opcode are latched when `start` is accepted. Later input changes have no effect on the operation in flight.
- **ADD/ADDI:** S=A+B. C=carry-out. F=signed overflow, i.e. (A,B same sign) & (S sign differs).
- **ADDU/ADDUI:** S=A+B. C=F=carry-out.
- **ADDC/ADDCI:** S=A+B+C_old. C=carry-out. F=signed overflow.
- **ADDCU (1010_0101) / ADDCUI (1010_0110):** S=A+B+C_old. C=F=carry-out.
- **SUB/SUBI:** S=A−B. C=borrow (A<B unsigned). F=(A sign≠B sign) & (S sign=B sign).
- **CMP/CMPI/CMPU (1010_0010):** S unchanged. L=A>B unsigned, Z=A==B, N=A>B signed. C and F cleared.
- **AND, OR, XOR:** flags unchanged.
- **NOT (1010_0011):** bitwise complement of A; flags unchanged.
- **MOV/MOVI:** S=A; flags unchanged.
- **Shifts:** LSH (1000_0100, LSHI 1000_xxxx), RSH (0000_1110, RSHI 1110_xxxx), ARSH (1010_0100).
  - Amount n=B[SHW−1:0]; one bit per cycle.
  - Vacated bits are zero, except ARSH, which replicates the MSB.
  - Flags unchanged. n=0 gives S=A.
- **MUL (1010_1000):** S=(A×B) mod 2^WIDTH, shift-add, one bit of B per cycle. Flags unchanged.
- **Undefined encodings:** `done` still pulses; S and flags unchanged. This replaces the old zero-output default.
- Flags not named for an operation keep their previous value.

## Timing
- **FSM states:**
  - IDLE → EXEC on accepted start of a shift with n>0, or of MUL.
  - EXEC → IDLE when the iteration counter reaches 0.
  - All other ops complete directly from IDLE.
- **Latency L**, counted from the accepting edge k: `done` is high for the cycle after edge k+L.
  - Single-cycle ops: L=1.
  - Shift: L=1+n for n>0; L=1 for n=0.
  - MUL: L=1+WIDTH.
- `busy` is high from edge k+1 until the edge on which `done` rises. It is low during the `done` cycle.
- Back-to-back: a `start` in the `done` cycle is accepted, and the new op sees the just-written C.
- `start` while `busy`=1 is ignored and not queued.
- **Reset:** `rst_n` low clears `busy`, `done`, `S`, `CLFZN` and the counter to 0, and forces IDLE. An operation in flight is aborted with no `done`.
- Wrap-around: adds are mod 2^WIDTH. For n=WIDTH−1, LSH leaves only A[0] in the MSB.

## Structure
- Package `alu_pkg`:
  - 8-bit `{opcode, opext}` constants; immediate-form match patterns use wildcard compare.
  - Flag bit indices `FLG_C`, `FLG_L`, `FLG_F`, `FLG_Z`, `FLG_N`.
  - FSM state enum.
- Sub-module `alu_iter_unit`: shift register plus counter shared by the shifts and MUL, with load/step/finished handshake to the top FSM.
- Single-cycle arithmetic, flag logic and the CLFZN register stay in the top level.

## Test plan
- **ADD/ADDC chaining:** WIDTH=16. ADD 0xFFFF+0x0001 → S=0x0000, C=1, F=0, done at L=1. Then ADDC 0x0001+0x0001 → S=0x0003, C=0.
- **Signed overflow:** ADD 0x7FFF+0x0001 → S=0x8000, F=1. SUB 0x8000−0x0001 → S=0x7FFF, F=1, C=0.
- **CMP and flag retention:** CMP A=0xFFFF, B=0x0001 → L=1, N=0, Z=0, S unchanged. Following AND leaves L=1 and N=0.
- **Shifts:** ARSH A=0x8000, B=5 → S=0xFC00 at L=6, with `busy` high for 5 cycles. Any `start` pulsed mid-op is ignored. LSH with n=0 → S=A at L=1.
- **MUL:** MUL 0x0123×0x0010 → S=0x1230 at L=17. Repeat at WIDTH=32 with 0x0001_0000×0x0001_0000 → S=0.
- **Reset abort:** assert `rst_n` low during MUL cycle 8 → all outputs 0, no `done`. A new ADD issued after release completes normally.
